// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the hart's data memory port. A word-organised SRAM
// sits behind a request handshake. Each request gets exactly one response
// after a fixed, parameterised latency. Only one request can be outstanding.
//
// Handshake (valid/ready):
//   - A request is "valid" while i_req_ren or i_req_wen is high.
//   - It is accepted on a rising edge of i_clk where o_req_ready is high.
//   - The requester holds addr/wdata/mask/ren/wen stable until that edge.
//   - Requests seen while o_req_ready is low are ignored.
//   - o_rsp_valid pulses for one cycle exactly LATENCY cycles after the
//     accept edge. There is no response backpressure.
//   - o_rsp_rdata and o_rsp_err are meaningful only while o_rsp_valid is high.
//
// Ports:
//   i_clk, i_rst     clock (rising edge), synchronous active-high reset
//   i_req_addr       byte address (word aligned)
//   i_req_ren        read request
//   i_req_wen        write request
//   i_req_wdata      write data, already placed on its byte lanes
//   i_req_mask       byte-lane enables, bit n covers [8n+7:8n]
//   o_req_ready      high only in IDLE; a request can be accepted
//   o_rsp_valid      one-cycle response pulse (RESP state)
//   o_rsp_rdata      read data, unmasked lanes forced to zero
//   o_rsp_err        illegal / misaligned / out-of-range / empty-mask access
//   o_dbg_state      current FSM state (0=IDLE, 1=WAIT, 2=RESP)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [1:0]  o_dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // Byte span of the array, kept 33 bits wide so a 4 GiB array cannot wrap.
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [31:0]      lane_bits;
    logic             req_err;
    logic             accept;

    // Unsigned subtraction: addresses below BASE_ADDR wrap to a huge offset
    // and fall out of range.
    always_comb begin
        offset    = i_req_addr - BASE_ADDR;
        idx       = offset[IDX_W+1:2];
        lane_bits = {{8{i_req_mask[3]}}, {8{i_req_mask[2]}},
                     {8{i_req_mask[1]}}, {8{i_req_mask[0]}}};
        req_err   = (i_req_ren & i_req_wen)
                  | (i_req_addr[1:0] != 2'b00)
                  | ({1'b0, offset} >= SPAN)
                  | (i_req_mask == 4'b0000);
        accept    = (state == IDLE) & (i_req_ren | i_req_wen);
    end

    // Memory array: no reset. The write commits on the accept edge, so a write
    // accepted before a later reset stays in the array.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept && i_req_wen && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (i_req_mask[b]) begin
                    mem[idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake/response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_req_ready <= 1'b0;
                        o_rsp_err   <= req_err;
                        // Errors and writes return zero data.
                        if (i_req_ren && !req_err) begin
                            o_rsp_rdata <= mem[idx] & lane_bits;
                        end else begin
                            o_rsp_rdata <= 32'd0;
                        end
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Leave on the edge that takes the counter from 1 to 0.
                    if (cnt == 4'd1) begin
                        state       <= RESP;
                        o_rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    o_rsp_valid <= 1'b0;
                    o_req_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    o_rsp_valid <= 1'b0;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Four instances with LATENCY 2, 1, 5 and
// 4 share clock and reset but have their own request/response signals. Every
// expected value below is written out by hand.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- per-instance signals ----------------
    logic [31:0] addr  [4];
    logic        ren   [4];
    logic        wen   [4];
    logic [31:0] wdata [4];
    logic [3:0]  mask  [4];
    logic        ready [4];
    logic        valid [4];
    logic [31:0] rdata [4];
    logic        err   [4];
    logic [1:0]  dbg   [4];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
        .i_clk(clk), .i_rst(rst),
        .i_req_addr(addr[0]), .i_req_ren(ren[0]), .i_req_wen(wen[0]),
        .i_req_wdata(wdata[0]), .i_req_mask(mask[0]),
        .o_req_ready(ready[0]), .o_rsp_valid(valid[0]),
        .o_rsp_rdata(rdata[0]), .o_rsp_err(err[0]), .o_dbg_state(dbg[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_addr(addr[1]), .i_req_ren(ren[1]), .i_req_wen(wen[1]),
        .i_req_wdata(wdata[1]), .i_req_mask(mask[1]),
        .o_req_ready(ready[1]), .o_rsp_valid(valid[1]),
        .o_rsp_rdata(rdata[1]), .o_rsp_err(err[1]), .o_dbg_state(dbg[1])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(5)) u_l5 (
        .i_clk(clk), .i_rst(rst),
        .i_req_addr(addr[2]), .i_req_ren(ren[2]), .i_req_wen(wen[2]),
        .i_req_wdata(wdata[2]), .i_req_mask(mask[2]),
        .o_req_ready(ready[2]), .o_rsp_valid(valid[2]),
        .o_rsp_rdata(rdata[2]), .o_rsp_err(err[2]), .o_dbg_state(dbg[2])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .i_clk(clk), .i_rst(rst),
        .i_req_addr(addr[3]), .i_req_ren(ren[3]), .i_req_wen(wen[3]),
        .i_req_wdata(wdata[3]), .i_req_mask(mask[3]),
        .o_req_ready(ready[3]), .o_rsp_valid(valid[3]),
        .o_rsp_rdata(rdata[3]), .o_rsp_err(err[3]), .o_dbg_state(dbg[3])
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one request on instance sel and follows it to its response.
    // With hold=1 the request stays on the port through WAIT/RESP and must
    // still be accepted only once.
    task automatic do_req(input int sel, input int lat,
                          input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input bit hold,
                          input logic [31:0] exp_data, input logic exp_err,
                          input string tag);
        int          waited;
        int          first;
        int          pulses;
        int          ready_bad;
        logic [31:0] got_d;
        logic        got_e;
        waited    = 0;
        first     = 0;
        pulses    = 0;
        ready_bad = 0;
        got_d     = 32'd0;
        got_e     = 1'b0;

        @(negedge clk);
        addr[sel]  = a;
        ren[sel]   = r;
        wen[sel]   = w;
        wdata[sel] = d;
        mask[sel]  = m;
        while (!ready[sel] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, 32'(waited < 50), 32'd1);

        @(posedge clk);
        #1;
        if (!hold) begin
            ren[sel] = 1'b0;
            wen[sel] = 1'b0;
        end

        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (valid[sel]) begin
                pulses++;
                if (first == 0) first = n;
                got_d = rdata[sel];
                got_e = err[sel];
            end
            if (ready[sel]) ready_bad++;
            if (n == lat) begin
                ren[sel] = 1'b0;
                wen[sel] = 1'b0;
            end
        end
        @(negedge clk);
        if (valid[sel]) pulses++;

        check({tag, "_lat"}, 32'(first), 32'(lat));
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_ready_lo"}, 32'(ready_bad), 32'd0);
        check({tag, "_ready_back"}, 32'(ready[sel]), 32'd1);
        check({tag, "_data"}, got_d, exp_data);
        check({tag, "_err"}, 32'(got_e), 32'(exp_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bad_valid;
        int bad_ready;

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr[i]  = 32'd0;
            ren[i]   = 1'b0;
            wen[i]   = 1'b0;
            wdata[i] = 32'd0;
            mask[i]  = 4'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", 32'(ready[i]), 32'd1);
            check("rst_valid", 32'(valid[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'd0);
            check("rst_err",   32'(err[i]), 32'd0);
        end
        rst = 1'b0;

        // Basic write then read, LATENCY=2.
        do_req(0, 2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, "wr10");
        do_req(0, 2, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, "rd10");

        // Byte lanes.
        do_req(0, 2, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b0, "wr20");
        do_req(0, 2, 1'b0, 1'b1, 32'h20, 32'hAB000000, 4'h8, 1'b0, 32'h0, 1'b0, "wr20_b3");
        do_req(0, 2, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'hAB223344, 1'b0, "rd20");
        do_req(0, 2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h3, 1'b0, 32'h00003344, 1'b0, "rd20_h0");

        // Errors.
        do_req(0, 2, 1'b1, 1'b0, 32'h22, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, "rd_misal");
        do_req(0, 2, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, "wr30");
        do_req(0, 2, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b1, "rw30");
        do_req(0, 2, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 32'h12345678, 1'b0, "rd30");
        do_req(0, 2, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, "rd_oor");
        do_req(0, 2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, "rd_mask0");
        do_req(0, 2, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, "wr_mask0");
        do_req(0, 2, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, "rd10_keep");
        do_req(0, 2, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, "rd_wrap");

        // Last word of the array.
        do_req(0, 2, 1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0, "wr_last");
        do_req(0, 2, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 1'b0, "rd_last");

        // LATENCY=1 and LATENCY=5, including a request held through WAIT.
        do_req(1, 1, 1'b0, 1'b1, 32'h8, 32'h01020304, 4'hF, 1'b0, 32'h0, 1'b0, "l1_wr");
        do_req(1, 1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1, 32'h01020304, 1'b0, "l1_rd_hold");
        do_req(2, 5, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0, 1'b0, "l5_wr_hold");
        do_req(2, 5, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'hA5A5A5A5, 1'b0, "l5_rd");
        do_req(2, 5, 1'b1, 1'b0, 32'h8, 32'h0, 4'h4, 1'b0, 32'h00A50000, 1'b0, "l5_rd_b2");

        // Reset during WAIT on the LATENCY=4 instance.
        @(negedge clk);
        addr[3]  = 32'h40;
        wdata[3] = 32'h00000055;
        mask[3]  = 4'h1;
        wen[3]   = 1'b1;
        check("rstmid_ready_pre", 32'(ready[3]), 32'd1);
        @(posedge clk);
        #1;
        wen[3] = 1'b0;
        @(negedge clk);
        check("rstmid_in_wait", 32'(dbg[3]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_ready_after", 32'(ready[3]), 32'd1);
        check("rstmid_state_after", 32'(dbg[3]), 32'd0);
        bad_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid[3]) bad_valid++;
        end
        check("rstmid_no_valid", 32'(bad_valid), 32'd0);
        do_req(3, 4, 1'b1, 1'b0, 32'h40, 32'h0, 4'h1, 1'b0, 32'h00000055, 1'b0, "rstmid_rd40");

        // Idle: no request for 10 cycles.
        bad_valid = 0;
        bad_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid[0]) bad_valid++;
            if (!ready[0]) bad_ready++;
        end
        check("idle_no_valid", 32'(bad_valid), 32'd0);
        check("idle_ready", 32'(bad_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the hart's data memory port (addr / ren / wen / wdata / mask / rdata).
- Replaces the combinational dmem model with a word-organised SRAM behind a ready/valid request handshake and a fixed, parameterised response latency.
- Supports exactly one outstanding request.
- Flags illegal, misaligned and out-of-range accesses so the pipelined hart can raise a trap.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 4.
LATENCY, 2, cycles from the accept edge to the o_rsp_valid cycle; legal range 1..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous reset, active-high.
i_req_addr  input  32  byte address; must be word aligned.
i_req_ren  input  1  read request.
i_req_wen  input  1  write request.
i_req_wdata  input  32  write data, already shifted to its byte lanes.
i_req_mask  input  4  byte-lane enables; bit n covers bits [8n+7:8n].
o_req_ready  output  1  responder can accept a request this cycle.
o_rsp_valid  output  1  one-cycle response pulse.
o_rsp_rdata  output  32  read data; valid only while o_rsp_valid is high.
o_rsp_err  output  1  error status; valid only while o_rsp_valid is high.

Behaviour:
- Reset: i_rst and i_clk are as already decided (synchronous, active-high reset i_rst; clock i_clk).
  - State goes to IDLE and the latency counter clears.
  - o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0 on the cycle after reset is sampled.
  - Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
  - o_req_ready=1 only in IDLE.
  - o_rsp_valid=1 only in RESP.
- Accept: on a rising edge where state=IDLE and (i_req_ren | i_req_wen).
  - If neither ren nor wen is high there is no accept and the responder stays in IDLE.
- On the accept edge:
  - Compute err = (ren & wen) | (addr[1:0]!=0) | (addr-BASE_ADDR >= DEPTH_WORDS*4) | (mask==0).
  - Word index = (addr-BASE_ADDR)>>2.
  - Write, no error: for each byte lane with mask=1, mem[idx] lane <= wdata lane. Other lanes are unchanged. The write commits on this edge.
  - Read, no error: response register <= mem[idx] with unmasked lanes forced to 0x00.
  - Any error: no memory update, response data <= 0, err captured as 1.
  - Write with no error: response data <= 0.
- Transitions:
  - IDLE -> RESP when LATENCY==1; otherwise IDLE -> WAIT with counter = LATENCY-1.
  - WAIT: counter decrements each cycle; WAIT -> RESP when the counter reaches 1 (decrement-to-zero edge).
  - RESP -> IDLE unconditionally after one cycle. There is no response backpressure.
- Timing:
  - The response appears exactly LATENCY cycles after the accept edge.
  - Next accept is possible LATENCY+1 edges after the previous accept.
  - Requests presented while o_req_ready=0 are ignored. The requester must hold the request until it is accepted.
- Read after write: a read accepted after a write's accept edge returns the written bytes (no stale data).
- Reset mid-operation: the pending response is dropped and no o_rsp_valid is produced. A write accepted before reset remains committed.
- Address arithmetic:
  - Unsigned 32-bit subtraction, so addr < BASE_ADDR wraps and yields err.
  - idx uses log2(DEPTH_WORDS) bits.
- o_rsp_rdata and o_rsp_err hold their last values outside RESP. Checkers must qualify them with o_rsp_valid.

Test Plan:
1. LATENCY=2. Write addr 0x10, wdata 0xDEADBEEF, mask 1111 at cycle 0, then read 0x10 mask 1111 on the next ready.
   -> Write response at cycle 2 with err=0. Read response carries 0xDEADBEEF, err=0. o_req_ready is low for cycles 1-2 after each accept.
2. Byte and half lanes. Write 0x11223344 mask 1111 to 0x20, then wdata 0xAB000000 mask 1000, then read mask 1111.
   -> Read returns 0xAB223344. A read of 0x20 with mask 0011 returns 0x00003344.
3. Errors.
   - Read addr 0x22 -> err=1, rdata 0.
   - ren=wen=1 at 0x30 -> err=1, and mem[0x30] is unchanged on a later read.
   - Read addr DEPTH_WORDS*4 -> err=1.
   - mask 0000 -> err=1.
4. Latency sweep with LATENCY=1 and LATENCY=5.
   -> o_rsp_valid rises exactly 1 and 5 cycles after the accept edge, lasts one cycle, and o_req_ready returns on the following cycle.
   - A request held during WAIT is accepted only once.
5. Reset mid-operation. LATENCY=4: accept a write of 0x55 to 0x40 mask 0001, then assert i_rst for one cycle during WAIT.
   -> No o_rsp_valid pulse appears, o_req_ready=1 after reset, and a later read of 0x40 mask 0001 returns 0x00000055.
6. Idle request: ren=wen=0 for 10 cycles -> no accept, o_rsp_valid stays 0, o_req_ready stays 1.
